// File: rtl/axi_write_master_phase2.sv
// rtl/axi_write_master_phase2.sv - phase-2 write engine: stream to AXI4 write bursts
//
// Accepts one write command (i_write_start, i_write_addr, i_xfer_size_in_bytes).
// Drains the input stream into AXI4 write bursts of up to C_BURST_LEN beats.
// Pulses o_write_done for one cycle once every B response has been received.
//
// Ports:
//   aclk, areset                      clock, asynchronous active-high reset
//   i_write_start, i_write_addr,
//   i_xfer_size_in_bytes              command (address 4 KB aligned, size multiple of BPB)
//   o_write_done, o_busy              completion pulse, command-in-progress flag
//   i_tvalid, o_tready, i_tdata       input stream
//   m_axi_aw*, m_axi_w*, m_axi_b*     AXI4 write address / data / response channels
module axi_write_master_phase2 #(
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_M_AXI_DATA_WIDTH = 512,
    parameter int C_XFER_SIZE_WIDTH  = 64,
    parameter int C_BURST_LEN        = 64,
    parameter int C_MAX_OUTSTANDING  = 16
) (
    input  logic                            aclk,
    input  logic                            areset,
    input  logic                            i_write_start,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   i_write_addr,
    input  logic [C_XFER_SIZE_WIDTH-1:0]    i_xfer_size_in_bytes,
    output logic                            o_write_done,
    output logic                            o_busy,
    input  logic                            i_tvalid,
    output logic                            o_tready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   i_tdata,
    output logic                            m_axi_awvalid,
    input  logic                            m_axi_awready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]                      m_axi_awlen,
    output logic                            m_axi_wvalid,
    input  logic                            m_axi_wready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                            m_axi_wlast,
    input  logic                            m_axi_bvalid,
    output logic                            m_axi_bready
);

    localparam int XW      = C_XFER_SIZE_WIDTH;
    localparam int AW      = C_M_AXI_ADDR_WIDTH;
    localparam int BPB     = C_M_AXI_DATA_WIDTH / 8;
    localparam int BPB_LOG = $clog2(BPB);
    localparam int BL_LOG  = $clog2(C_BURST_LEN);
    localparam int OUT_W   = $clog2(C_MAX_OUTSTANDING + 1);

    localparam logic [XW-1:0]    BL_X        = XW'(C_BURST_LEN);
    localparam logic [AW-1:0]    BURST_BYTES = AW'(C_BURST_LEN * BPB);
    localparam logic [OUT_W-1:0] MAX_OUT     = OUT_W'(C_MAX_OUTSTANDING);
    localparam logic [8:0]       LAST_BEAT   = 9'(C_BURST_LEN - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]       state;
    logic [XW-1:0]    nbursts;
    logic [XW-1:0]    aw_issued;
    logic [XW-1:0]    w_bursts_done;
    logic [XW-1:0]    b_received;
    logic [XW-1:0]    aw_beats_left;   // beats not yet covered by an issued AW
    logic [XW-1:0]    w_beats_left;    // beats not yet accepted on W
    logic [8:0]       w_beat;          // beat index inside the current W burst
    logic [OUT_W-1:0] outstanding;
    logic [AW-1:0]    awaddr_q;
    logic [7:0]       awlen_q;

    logic          w_en;
    logic          aw_hs;
    logic          w_hs;
    logic          b_hs;
    logic [XW-1:0] start_beats;
    logic [XW-1:0] aw_left_nxt;

    // awlen for a burst that starts with `beats` remaining
    function automatic logic [7:0] len_of(input logic [XW-1:0] beats);
        if (beats == '0)
            return 8'd0;
        else if (beats >= BL_X)
            return 8'(C_BURST_LEN - 1);
        else
            return 8'(beats - 1'b1);
    endfunction

    assign start_beats = i_xfer_size_in_bytes >> BPB_LOG;
    assign aw_left_nxt = (aw_beats_left > BL_X) ? aw_beats_left - BL_X : '0;

    assign m_axi_awvalid = (state == S_ACTIVE) && (aw_issued < nbursts) && (outstanding < MAX_OUT);
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awlen   = awlen_q;

    // W may only carry beats of bursts whose AW has already been accepted
    assign w_en          = (state == S_ACTIVE) && (w_bursts_done < aw_issued);
    assign m_axi_wvalid  = i_tvalid & w_en;
    assign o_tready      = m_axi_wready & w_en;
    assign m_axi_wdata   = i_tdata;
    assign m_axi_wstrb   = '1;
    // Only the final burst can be short, so the overall last beat also ends a burst
    assign m_axi_wlast   = w_en && ((w_beat == LAST_BEAT) || (w_beats_left == XW'(1)));

    assign m_axi_bready  = (state == S_ACTIVE) || (state == S_DRAIN);
    assign o_write_done  = (state == S_DONE);
    assign o_busy        = (state != S_IDLE);

    assign aw_hs = m_axi_awvalid & m_axi_awready;
    assign w_hs  = m_axi_wvalid & m_axi_wready;
    assign b_hs  = m_axi_bvalid & m_axi_bready;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state         <= S_IDLE;
            nbursts       <= '0;
            aw_issued     <= '0;
            w_bursts_done <= '0;
            b_received    <= '0;
            aw_beats_left <= '0;
            w_beats_left  <= '0;
            w_beat        <= '0;
            outstanding   <= '0;
            awaddr_q      <= '0;
            awlen_q       <= '0;
        end else begin
            if (aw_hs) begin
                aw_issued     <= aw_issued + 1'b1;
                awaddr_q      <= awaddr_q + BURST_BYTES;
                aw_beats_left <= aw_left_nxt;
                awlen_q       <= len_of(aw_left_nxt);
            end
            if (w_hs) begin
                w_beats_left <= w_beats_left - 1'b1;
                w_beat       <= m_axi_wlast ? 9'd0 : w_beat + 1'b1;
                if (m_axi_wlast)
                    w_bursts_done <= w_bursts_done + 1'b1;
            end
            if (b_hs)
                b_received <= b_received + 1'b1;

            case ({aw_hs, b_hs})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase

            case (state)
                S_IDLE: begin
                    if (i_write_start) begin
                        awaddr_q      <= i_write_addr;
                        awlen_q       <= len_of(start_beats);
                        aw_beats_left <= start_beats;
                        w_beats_left  <= start_beats;
                        nbursts       <= (start_beats + XW'(C_BURST_LEN - 1)) >> BL_LOG;
                        aw_issued     <= '0;
                        w_bursts_done <= '0;
                        b_received    <= '0;
                        w_beat        <= '0;
                        outstanding   <= '0;
                        state         <= (start_beats == '0) ? S_DONE : S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (w_hs && (w_beats_left == XW'(1)))
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    // count the response landing this edge so done follows the last B by one cycle
                    if ((b_received + XW'(b_hs)) == nbursts)
                        state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_write_master_phase2.sv
// tb/tb_axi_write_master_phase2.sv - scoreboard bench for axi_write_master_phase2
module tb_axi_write_master_phase2;

    localparam int DW  = 512;
    localparam int AWD = 64;
    localparam int XW  = 64;
    localparam int BL  = 64;
    localparam int BPB = DW / 8;

    typedef struct packed {
        logic [AWD-1:0] addr;
        logic [7:0]     len;
    } aw_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } w_t;

    logic           aclk = 1'b0;
    logic           areset;
    logic           i_write_start;
    logic [AWD-1:0] i_write_addr;
    logic [XW-1:0]  i_xfer_size_in_bytes;
    logic           o_write_done;
    logic           o_busy;
    logic           i_tvalid;
    logic           o_tready;
    logic [DW-1:0]  i_tdata;
    logic           m_axi_awvalid;
    logic           m_axi_awready;
    logic [AWD-1:0] m_axi_awaddr;
    logic [7:0]     m_axi_awlen;
    logic           m_axi_wvalid;
    logic           m_axi_wready;
    logic [DW-1:0]  m_axi_wdata;
    logic [DW/8-1:0] m_axi_wstrb;
    logic           m_axi_wlast;
    logic           m_axi_bvalid;
    logic           m_axi_bready;

    always #5 aclk = ~aclk;

    axi_write_master_phase2 dut (
        .aclk                 (aclk),
        .areset               (areset),
        .i_write_start        (i_write_start),
        .i_write_addr         (i_write_addr),
        .i_xfer_size_in_bytes (i_xfer_size_in_bytes),
        .o_write_done         (o_write_done),
        .o_busy               (o_busy),
        .i_tvalid             (i_tvalid),
        .o_tready             (o_tready),
        .i_tdata              (i_tdata),
        .m_axi_awvalid        (m_axi_awvalid),
        .m_axi_awready        (m_axi_awready),
        .m_axi_awaddr         (m_axi_awaddr),
        .m_axi_awlen          (m_axi_awlen),
        .m_axi_wvalid         (m_axi_wvalid),
        .m_axi_wready         (m_axi_wready),
        .m_axi_wdata          (m_axi_wdata),
        .m_axi_wstrb          (m_axi_wstrb),
        .m_axi_wlast          (m_axi_wlast),
        .m_axi_bvalid         (m_axi_bvalid),
        .m_axi_bready         (m_axi_bready)
    );

    int checks   = 0;
    int failures = 0;

    aw_t           exp_aw_q[$];
    w_t            exp_w_q[$];
    logic [DW-1:0] stream_q[$];

    int  pend_b        = 0;
    int  done_expected = 0;
    int  done_cnt      = 0;
    int  aw_cnt        = 0;
    int  b_cnt         = 0;
    int  aw_tot        = 0;
    int  b_tot         = 0;
    int  exp_nb        = 0;
    int  cmd_done0     = 0;
    bit  any_valid     = 0;
    bit  stall         = 0;
    bit  bhold         = 0;
    bit  aw_hs_f       = 0;
    bit  w_hs_f        = 0;
    bit  b_hs_f        = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            if (DW > 64)
                $display("FAIL %s actual=%0h required=%0h", name, act[63:0], req[63:0]);
            else
                $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++)
            v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Monitor: samples on the falling edge, when every signal is settled
    always @(negedge aclk) begin
        aw_hs_f = m_axi_awvalid && m_axi_awready;
        w_hs_f  = m_axi_wvalid && m_axi_wready;
        b_hs_f  = m_axi_bvalid && m_axi_bready;
        if (m_axi_awvalid || m_axi_wvalid)
            any_valid = 1;
        if (aw_hs_f) begin
            chk("aw_outstanding_below_max", DW'(aw_tot - b_tot < 16), DW'(1));
            aw_tot++;
            aw_cnt++;
            chk("aw_expected", DW'(exp_aw_q.size() != 0), DW'(1));
            if (exp_aw_q.size() != 0) begin
                aw_t e;
                e = exp_aw_q.pop_front();
                chk("awaddr", DW'(m_axi_awaddr), DW'(e.addr));
                chk("awlen", DW'(m_axi_awlen), DW'(e.len));
            end
        end
        if (w_hs_f) begin
            chk("w_expected", DW'(exp_w_q.size() != 0), DW'(1));
            if (exp_w_q.size() != 0) begin
                w_t e;
                e = exp_w_q.pop_front();
                chk("wdata", m_axi_wdata, e.data);
                chk("wlast", DW'(m_axi_wlast), DW'(e.last));
                chk("wstrb", DW'(m_axi_wstrb), DW'({(DW/8){1'b1}}));
            end
            if (m_axi_wlast)
                pend_b++;
        end
        if (b_hs_f) begin
            b_tot++;
            b_cnt++;
            if (pend_b > 0)
                pend_b--;
        end
        if (o_write_done) begin
            done_cnt++;
            chk("done_expected", DW'(done_expected > 0), DW'(1));
            if (done_expected > 0)
                done_expected--;
        end
    end

    // Stream source and AXI slave: drive just after the rising edge
    always @(posedge aclk) begin
        #1;
        if (w_hs_f && stream_q.size() > 0)
            stream_q.delete(0);
        i_tvalid      = (stream_q.size() > 0) && (!stall || $urandom_range(0, 3) != 0);
        i_tdata       = (stream_q.size() > 0) ? stream_q[0] : '0;
        m_axi_awready = !stall || $urandom_range(0, 2) != 0;
        m_axi_wready  = !stall || $urandom_range(0, 2) != 0;
        m_axi_bvalid  = (pend_b > 0) && !bhold && (!stall || $urandom_range(0, 1) != 0);
    end

    // Reference: split the command into bursts from the byte count alone
    task automatic run_cmd(input logic [AWD-1:0] addr, input logic [XW-1:0] size);
        int beats;
        int left;
        int k;
        @(posedge aclk);
        #2;
        beats = int'(size / BPB);
        left  = beats;
        k     = 0;
        while (left > 0) begin
            int n;
            aw_t a;
            n = (left > BL) ? BL : left;
            a.addr = addr + AWD'(k) * AWD'(BL * BPB);
            a.len  = 8'(n - 1);
            exp_aw_q.push_back(a);
            for (int b = 0; b < n; b++) begin
                w_t w;
                w.data = rand_word();
                w.last = (b == n - 1);
                exp_w_q.push_back(w);
                stream_q.push_back(w.data);
            end
            left -= n;
            k++;
        end
        exp_nb    = k;
        aw_cnt    = 0;
        b_cnt     = 0;
        any_valid = 0;
        cmd_done0 = done_cnt;
        done_expected++;
        i_write_start        = 1'b1;
        i_write_addr         = addr;
        i_xfer_size_in_bytes = size;
        @(posedge aclk);
        #2;
        i_write_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int i = 0; i < budget && done_cnt == cmd_done0; i++)
            @(posedge aclk);
        #2;
        chk({name, "_done_seen"}, DW'(done_cnt - cmd_done0), DW'(1));
        chk({name, "_busy_cleared"}, DW'(o_busy), DW'(0));
        chk({name, "_aw_count"}, DW'(aw_cnt), DW'(exp_nb));
        chk({name, "_b_count"}, DW'(b_cnt), DW'(exp_nb));
        chk({name, "_w_all_sent"}, DW'(exp_w_q.size()), DW'(0));
        repeat (4) @(posedge aclk);
        #2;
        chk({name, "_single_done"}, DW'(done_cnt - cmd_done0), DW'(1));
    endtask

    task automatic chk_outputs_zero(input string name);
        chk({name, "_awvalid"}, DW'(m_axi_awvalid), DW'(0));
        chk({name, "_wvalid"}, DW'(m_axi_wvalid), DW'(0));
        chk({name, "_wlast"}, DW'(m_axi_wlast), DW'(0));
        chk({name, "_bready"}, DW'(m_axi_bready), DW'(0));
        chk({name, "_tready"}, DW'(o_tready), DW'(0));
        chk({name, "_done"}, DW'(o_write_done), DW'(0));
        chk({name, "_busy"}, DW'(o_busy), DW'(0));
        chk({name, "_awaddr"}, DW'(m_axi_awaddr), DW'(0));
        chk({name, "_awlen"}, DW'(m_axi_awlen), DW'(0));
    endtask

    initial begin
        areset               = 1'b1;
        i_write_start        = 1'b0;
        i_write_addr         = '0;
        i_xfer_size_in_bytes = '0;
        i_tvalid             = 1'b0;
        i_tdata              = '0;
        m_axi_awready        = 1'b0;
        m_axi_wready         = 1'b0;
        m_axi_bvalid         = 1'b0;
        #2;
        chk_outputs_zero("reset");
        repeat (3) @(posedge aclk);
        #2;
        areset = 1'b0;

        run_cmd(64'h1_0000_0000, 64'd16384);
        wait_done("full4", 2000);

        run_cmd(64'h1_0000_0000, 64'd4160);
        wait_done("rem65", 1000);

        run_cmd(64'h2_0000_0000, 64'd0);
        chk("zero_done_at_n1", DW'(o_write_done), DW'(1));
        wait_done("zero", 20);
        chk("zero_no_traffic", DW'(any_valid), DW'(0));

        bhold = 1;
        run_cmd(64'h3_0000_0000, 64'd131072);
        repeat (1500) @(posedge aclk);
        #2;
        chk("hold_aw_count", DW'(aw_cnt), DW'(16));
        chk("hold_awvalid_low", DW'(m_axi_awvalid), DW'(0));
        bhold = 0;
        wait_done("hold", 5000);

        stall = 1;
        run_cmd(64'h4_0000_0000, 64'd8192);
        wait_done("stall", 3000);

        for (int r = 0; r < 3; r++) begin
            logic [AWD-1:0] a;
            logic [XW-1:0]  s;
            a = AWD'($urandom_range(0, 255)) << 12;
            s = XW'($urandom_range(1, 300)) * XW'(BPB);
            stall = 1'($urandom_range(0, 1));
            run_cmd(a, s);
            wait_done("random", 3000);
        end
        stall = 0;

        run_cmd(64'h5_0000_0000, 64'd16384);
        repeat (100) @(posedge aclk);
        #3;
        areset = 1'b1;
        exp_aw_q.delete();
        exp_w_q.delete();
        stream_q.delete();
        pend_b        = 0;
        done_expected = 0;
        #1;
        chk_outputs_zero("midreset");
        repeat (3) @(posedge aclk);
        #2;
        areset = 1'b0;
        cmd_done0 = done_cnt;
        repeat (5) @(posedge aclk);
        #2;
        chk("no_stale_done", DW'(done_cnt - cmd_done0), DW'(0));
        run_cmd(64'h6_0000_0000, 64'd4096);
        wait_done("after_reset", 1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_write_master_phase2.md
# axi_write_master_phase2

Phase-2 write engine: accepts one write command (start pulse, base address, byte count) from the phase-2 address calculator, drains the merge-tree output stream into AXI4 write bursts on one memory channel, and returns a one-cycle write-done pulse. The address calculator relies on this pulse to select the next write region. The engine sits between the merge-tree output and the AXI write port.

## Interface
- C_M_AXI_ADDR_WIDTH, 64, AXI address width
- C_M_AXI_DATA_WIDTH, 512, AXI/stream data width; bytes per beat BPB = C_M_AXI_DATA_WIDTH/8 (64)
- C_XFER_SIZE_WIDTH, 64, byte-count width
- C_BURST_LEN, 64, maximum beats per burst (power of two, ≤256)
- C_MAX_OUTSTANDING, 16, maximum bursts with AW accepted and B not yet received

Ports:
- aclk  in  1  clock
- areset  in  1  reset; one clock, reset asynchronous, active-high
- i_write_start  in  1  command pulse
- i_write_addr  in  C_M_AXI_ADDR_WIDTH  base byte address; 4 KB aligned
- i_xfer_size_in_bytes  in  C_XFER_SIZE_WIDTH  bytes to write; multiple of BPB
- o_write_done  out  1  one-cycle pulse when all B responses are received
- o_busy  out  1  command in progress
- i_tvalid / o_tready / i_tdata  in/out/in  1/1/DATA  input stream
- m_axi_awvalid, m_axi_awready  out/in  1
- m_axi_awaddr  out  ADDR;  m_axi_awlen  out  8
- m_axi_wvalid, m_axi_wready  out/in  1;  m_axi_wdata  out  DATA;  m_axi_wstrb  out  DATA/8 (all ones);  m_axi_wlast  out  1
- m_axi_bvalid, m_axi_bready  in/out  1

## Operation
- States: IDLE → ACTIVE → DRAIN → DONE → IDLE.
- IDLE: i_write_start latches the address and the beat total, total_beats = size >> log2(BPB). If total_beats = 0, go to DONE. Otherwise go to ACTIVE. i_write_start outside IDLE is ignored.
- Burst split:
  - nbursts = ceil(total_beats / C_BURST_LEN).
  - All bursts are full except the last, which carries the remainder.
  - awlen = beats − 1.
  - Burst k is at base + k·C_BURST_LEN·BPB.
  - Address arithmetic is full width; no 4 KB crossing occurs given aligned base and C_BURST_LEN·BPB ≤ 4096.
- AW channel:
  - awvalid is asserted while aw_issued < nbursts and outstanding < C_MAX_OUTSTANDING.
  - awaddr/awlen are held stable until the handshake.
  - outstanding increments on AW handshake and decrements on B handshake; both in one cycle leave it unchanged.
- W channel:
  - Enabled while w_bursts_done < aw_issued, so W never leads AW.
  - m_axi_wvalid = i_tvalid & enable; o_tready = m_axi_wready & enable; wdata = i_tdata (combinational pass-through).
  - wlast is asserted on the final beat of the current burst, using a beat counter that is reset per burst.
- B channel: bready = 1 in ACTIVE and DRAIN, 0 otherwise. bresp is ignored.
- ACTIVE → DRAIN once all W beats are sent. DRAIN → DONE when b_received = nbursts.
- DONE: o_write_done = 1 for exactly one cycle, then IDLE.
- o_busy = 1 in ACTIVE, DRAIN and DONE.
- Reset values: all outputs 0 (awvalid, wvalid, wlast, bready, o_tready, o_write_done, o_busy, awaddr, awlen); state IDLE; counters 0.
- Reset mid-operation: the command is abandoned, valids drop asynchronously, and no done pulse is issued.

## Timing
- Start sampled at edge N → awvalid with burst-0 address at N+1; W is enabled from the cycle after the AW handshake.
- Back-to-back AW: the next burst is presented the cycle after a handshake; one AW per cycle at most.
- Sustained throughput of 1 W beat/cycle when tvalid and wready are held high.
- Last B handshake at edge M → o_write_done high during M+1 → IDLE at M+2; a new start is accepted from M+2.
- Zero-size command: done pulse at N+1, no AXI traffic.

## Test plan
- Base 0x1_0000_0000, size 16384, all ready: 4 AW with awlen 63 at +0x0, +0x1000, +0x2000, +0x3000; 256 W beats with wlast every 64th; exactly one o_write_done after the 4th B.
- Size 4160: 2 AW (awlen 63, then awlen 0 at +0x1000); 65 beats; wlast on beats 64 and 65; one done pulse.
- Size 0: o_write_done pulses at N+1, with no awvalid or wvalid ever asserted.
- Size 131072, bvalid held 0: exactly 16 AW accepted, then awvalid stays 0. Releasing bvalid completes the remaining 16 bursts and produces one done pulse.
- Random tvalid/wready/awready stalls with size 8192: data order is preserved, wdata equals the stream, and the AW and B counts equal 2.
- areset asserted mid-burst, then a new size-4096 command: outputs are 0 during reset, no stale done pulse, and the new command completes cleanly.
